bpred_pht_ctrl: RTL and testbench

BPRED_PHT_CTRL -- requirements
Module: bpred_pht_ctrl

---
 rtl/config_pkg.sv | 11 +
 rtl/phtupdq.sv | 79 +++++++
 rtl/bpred_pht_ctrl.sv | 126 ++++++++++++
 tb/tb_bpred_pht_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared types and constants for the PHT write-port controller.
package config_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } pht_state_e;

  localparam int unsigned PhtCtrWidth = 2;

endpackage

// File: rtl/phtupdq.sv
// Small circular FIFO of pending PHT updates {index, data}; the newest entry's
// data can be overwritten in place (coalesce) without changing occupancy.
module phtupdq #(
  parameter int unsigned K     = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         coal_i,
  input  logic [K-1:0] idx_i,
  input  logic [1:0]   data_i,
  output logic [K-1:0] head_idx_o,
  output logic [1:0]   head_data_o,
  output logic [K-1:0] tail_idx_o,
  output logic         single_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [K-1:0]  idx_q  [DEPTH];
  logic [1:0]    data_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, tail_ptr;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
  endfunction

  assign tail_ptr    = ptr_dec(wr_q);
  assign head_idx_o  = idx_q[rd_q];
  assign head_data_o = data_q[rd_q];
  assign tail_idx_o  = idx_q[tail_ptr];
  assign single_o    = (cnt_q == CW'(1));
  assign full_o      = (cnt_q == CW'(DEPTH));
  assign empty_o     = (cnt_q == '0);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop_i)  rd_d = ptr_inc(rd_q);
    if (push_i) wr_d = ptr_inc(wr_q);
    if (push_i && !pop_i)      cnt_d = cnt_q + CW'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage needs no reset: occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_i) begin
      idx_q[wr_q]  <= idx_i;
      data_q[wr_q] <= data_i;
    end else if (coal_i) begin
      data_q[tail_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/bpred_pht_ctrl.sv
// Single PHT write-port arbiter: clear sweep, debug writes, and branch updates
// (bypassed when possible, otherwise buffered in a small coalescing queue).
module bpred_pht_ctrl
  import config_pkg::*;
#(
  parameter int unsigned K       = 10,
  parameter logic [1:0]  INITVAL = 2'b01,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ClearReq,
  input  logic         UpdValid,
  input  logic [K-1:0] UpdIndex,
  input  logic [1:0]   UpdData,
  input  logic         DbgWrValid,
  input  logic [K-1:0] DbgWrIndex,
  input  logic [1:0]   DbgWrData,
  output logic         DbgWrReady,
  output logic         PHTWe,
  output logic [K-1:0] PHTWa,
  output logic [1:0]   PHTWd,
  output logic         Busy,
  output logic         UpdDrop
);

  pht_state_e   state_q, state_d;
  logic [K-1:0] ctr_q, ctr_d;

  logic         q_push, q_pop, q_coal, q_flush;
  logic [K-1:0] q_head_idx, q_tail_idx;
  logic [1:0]   q_head_data;
  logic         q_single, q_full, q_empty;
  logic         we, rdy, drop;
  logic [K-1:0] wa;
  logic [1:0]   wd;

  phtupdq #(.K(K), .DEPTH(QDEPTH)) u_updq (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (q_flush),
    .push_i      (q_push),
    .pop_i       (q_pop),
    .coal_i      (q_coal),
    .idx_i       (UpdIndex),
    .data_i      (UpdData),
    .head_idx_o  (q_head_idx),
    .head_data_o (q_head_data),
    .tail_idx_o  (q_tail_idx),
    .single_o    (q_single),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    rdy     = 1'b0;
    drop    = 1'b0;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_coal  = 1'b0;
    q_flush = 1'b0;
    if (reset) begin
      // Everything held quiet; registers are reset in the sequential block.
    end else if (ClearReq) begin
      if (state_q == SWEEP) begin
        we = 1'b1;
        wa = ctr_q;
        wd = INITVAL;
      end
      state_d = SWEEP;
      ctr_d   = '0;
      q_flush = 1'b1;
    end else if (state_q == SWEEP) begin
      we    = 1'b1;
      wa    = ctr_q;
      wd    = INITVAL;
      ctr_d = ctr_q + K'(1);
      if (ctr_q == '1) state_d = IDLE;
    end else begin
      rdy = 1'b1;
      if (DbgWrValid) begin
        we = 1'b1;
        wa = DbgWrIndex;
        wd = DbgWrData;
      end else if (!q_empty) begin
        we    = 1'b1;
        wa    = q_head_idx;
        wd    = q_head_data;
        q_pop = 1'b1;
      end else if (UpdValid) begin
        we = 1'b1;
        wa = UpdIndex;
        wd = UpdData;
      end
      // Update not bypassed: coalesce onto the newest entry unless it is leaving now.
      if (UpdValid && !(q_empty && !DbgWrValid)) begin
        if (!q_empty && UpdIndex == q_tail_idx && !(q_pop && q_single)) q_coal = 1'b1;
        else if (q_full && !q_pop)                                      drop   = 1'b1;
        else                                                            q_push = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  assign PHTWe      = we;
  assign PHTWa      = wa;
  assign PHTWd      = wd;
  assign DbgWrReady = rdy;
  assign UpdDrop    = drop;
  assign Busy       = reset || (state_q == SWEEP);

endmodule

// File: tb/tb_bpred_pht_ctrl.sv
// Directed bench for bpred_pht_ctrl with K=4 (16-entry table).
module tb_bpred_pht_ctrl;

  logic       clk;
  logic       reset;
  logic       ClearReq;
  logic       UpdValid;
  logic [3:0] UpdIndex;
  logic [1:0] UpdData;
  logic       DbgWrValid;
  logic [3:0] DbgWrIndex;
  logic [1:0] DbgWrData;
  logic       DbgWrReady;
  logic       PHTWe;
  logic [3:0] PHTWa;
  logic [1:0] PHTWd;
  logic       Busy;
  logic       UpdDrop;

  int total = 0;
  int bad   = 0;

  bpred_pht_ctrl #(.K(4), .INITVAL(2'b01), .QDEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .ClearReq   (ClearReq),
    .UpdValid   (UpdValid),
    .UpdIndex   (UpdIndex),
    .UpdData    (UpdData),
    .DbgWrValid (DbgWrValid),
    .DbgWrIndex (DbgWrIndex),
    .DbgWrData  (DbgWrData),
    .DbgWrReady (DbgWrReady),
    .PHTWe      (PHTWe),
    .PHTWa      (PHTWa),
    .PHTWd      (PHTWd),
    .Busy       (Busy),
    .UpdDrop    (UpdDrop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drv(input logic dv, input logic [3:0] di, input logic [1:0] dd,
                     input logic uv, input logic [3:0] ui, input logic [1:0] ud,
                     input logic clr);
    DbgWrValid = dv;
    DbgWrIndex = di;
    DbgWrData  = dd;
    UpdValid   = uv;
    UpdIndex   = ui;
    UpdData    = ud;
    ClearReq   = clr;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] wa,
                        input logic [1:0] wd, input logic drop);
    chk({tag, "_we"}, 32'(PHTWe), 32'(we));
    chk({tag, "_wa"}, 32'(PHTWa), 32'(wa));
    chk({tag, "_wd"}, 32'(PHTWd), 32'(wd));
    chk({tag, "_drop"}, 32'(UpdDrop), 32'(drop));
  endtask

  // Full 16-cycle sweep from index 0 with junk updates/debug requests present.
  task automatic sweep_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 4'hF, 2'd3, 1'b1, 4'(i), 2'd2, 1'b0);
      settle();
      chk_wr(tag, 1'b1, 4'(i), 2'b01, 1'b0);
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      chk({tag, "_rdy"}, 32'(DbgWrReady), 32'd0);
      tick();
    end
    drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0);
    settle();
    chk({tag, "_end_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_end_rdy"}, 32'(DbgWrReady), 32'd1);
    chk_wr({tag, "_end"}, 1'b0, 4'd0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    drv(1'b1, 4'd2, 2'd2, 1'b1, 4'd3, 2'd3, 1'b0);
    settle();
    chk_wr("rst", 1'b0, 4'd0, 2'd0, 1'b0);
    chk("rst_busy", 32'(Busy), 32'd1);
    chk("rst_rdy", 32'(DbgWrReady), 32'd0);
    tick();
    reset = 1'b0;
    sweep_all("sweep0");
    tick();

    // Bypass into an empty queue.
    drv(1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 2'd3, 1'b0); settle();
    chk_wr("byp", 1'b1, 4'd5, 2'd3, 1'b0);
    tick(); drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0); settle();
    chk_wr("byp_after", 1'b0, 4'd0, 2'd0, 1'b0);
    tick();

    // Debug write blocks three cycles: third update overflows.
    drv(1'b1, 4'hA, 2'd2, 1'b1, 4'd1, 2'd1, 1'b0); settle();
    chk_wr("ovf_a", 1'b1, 4'hA, 2'd2, 1'b0);
    tick(); drv(1'b1, 4'hA, 2'd2, 1'b1, 4'd2, 2'd2, 1'b0); settle();
    chk_wr("ovf_b", 1'b1, 4'hA, 2'd2, 1'b0);
    tick(); drv(1'b1, 4'hA, 2'd2, 1'b1, 4'd3, 2'd3, 1'b0); settle();
    chk_wr("ovf_c", 1'b1, 4'hA, 2'd2, 1'b1);
    tick(); drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0); settle();
    chk_wr("ovf_q1", 1'b1, 4'd1, 2'd1, 1'b0);
    tick(); settle();
    chk_wr("ovf_q2", 1'b1, 4'd2, 2'd2, 1'b0);
    tick(); settle();
    chk_wr("ovf_empty", 1'b0, 4'd0, 2'd0, 1'b0);
    tick();

    // Two updates to the same index coalesce behind a debug write.
    drv(1'b1, 4'hB, 2'd0, 1'b1, 4'd7, 2'd2, 1'b0); settle();
    chk_wr("coal_a", 1'b1, 4'hB, 2'd0, 1'b0);
    tick(); drv(1'b1, 4'hB, 2'd0, 1'b1, 4'd7, 2'd3, 1'b0); settle();
    chk_wr("coal_b", 1'b1, 4'hB, 2'd0, 1'b0);
    tick(); drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0); settle();
    chk_wr("coal_q", 1'b1, 4'd7, 2'd3, 1'b0);
    tick(); settle();
    chk_wr("coal_empty", 1'b0, 4'd0, 2'd0, 1'b0);
    tick();

    // Full queue draining in the same cycle accepts a new update.
    drv(1'b1, 4'hC, 2'd1, 1'b1, 4'd1, 2'd0, 1'b0); tick();
    drv(1'b1, 4'hC, 2'd1, 1'b1, 4'd2, 2'd1, 1'b0); tick();
    drv(1'b0, 4'd0, 2'd0, 1'b1, 4'd4, 2'd1, 1'b0); settle();
    chk_wr("drain_a", 1'b1, 4'd1, 2'd0, 1'b0);
    tick(); drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0); settle();
    chk_wr("drain_b", 1'b1, 4'd2, 2'd1, 1'b0);
    tick(); settle();
    chk_wr("drain_c", 1'b1, 4'd4, 2'd1, 1'b0);
    tick(); settle();
    chk_wr("drain_empty", 1'b0, 4'd0, 2'd0, 1'b0);
    tick();

    // Same index as a lone entry being written now: both values reach the table.
    drv(1'b1, 4'hD, 2'd0, 1'b1, 4'd6, 2'd1, 1'b0); tick();
    drv(1'b0, 4'd0, 2'd0, 1'b1, 4'd6, 2'd2, 1'b0); settle();
    chk_wr("lone_a", 1'b1, 4'd6, 2'd1, 1'b0);
    tick(); drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0); settle();
    chk_wr("lone_b", 1'b1, 4'd6, 2'd2, 1'b0);
    tick();

    // ClearReq in IDLE with a queued entry, then restart mid-sweep at index 9.
    drv(1'b1, 4'hE, 2'd3, 1'b1, 4'd5, 2'd0, 1'b0); tick();
    drv(1'b1, 4'hE, 2'd3, 1'b1, 4'd8, 2'd0, 1'b1); settle();
    chk_wr("clr_idle", 1'b0, 4'd0, 2'd0, 1'b0);
    chk("clr_idle_rdy", 32'(DbgWrReady), 32'd0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0); tick();
    end
    drv(1'b0, 4'd0, 2'd0, 1'b1, 4'd2, 2'd2, 1'b1); settle();
    chk_wr("clr_mid", 1'b1, 4'd9, 2'b01, 1'b0);
    tick();
    sweep_all("sweep1");
    tick(); settle();
    chk_wr("clr_noreplay", 1'b0, 4'd0, 2'd0, 1'b0);
    tick();

    // Reset with an entry queued discards it.
    drv(1'b1, 4'h1, 2'd1, 1'b1, 4'd3, 2'd3, 1'b0); tick();
    drv(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0, 1'b0);
    reset = 1'b1; settle();
    chk_wr("rst2", 1'b0, 4'd0, 2'd0, 1'b0);
    chk("rst2_busy", 32'(Busy), 32'd1);
    tick();
    reset = 1'b0;
    sweep_all("sweep2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
